// File: rtl/complex_acc.sv
// complex_acc: frame integrator for signed complex products with dump pulse.
// Optional COMPLEX_ACC_SAT_EN: saturating adds plus per-frame sticky out_sat.
module complex_acc #(
    parameter int IN_W    = 16,
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 20,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    input  logic             flush,
    output logic [ACC_W-1:0] acc_real,
    output logic [ACC_W-1:0] acc_imag,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    output logic             busy,
    output logic             out_sat
);

    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] sum_re, sum_im, sum_re_nx, sum_im_nx;
    logic [ACC_W-1:0] ext_re, ext_im, add_re, add_im;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             sat, sat_nx, add_ovf;

    assign ext_re  = ACC_W'($signed(in_real));
    assign ext_im  = ACC_W'($signed(in_imag));
    assign cnt_inc = cnt + CNT_W'(1);
    assign busy    = (state != IDLE);

`ifdef COMPLEX_ACC_SAT_EN
    localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] full_re, full_im;
    logic           ovf_re, ovf_im;

    // One guard bit: overflow when it disagrees with the result sign
    assign full_re = {sum_re[ACC_W-1], sum_re} + {ext_re[ACC_W-1], ext_re};
    assign full_im = {sum_im[ACC_W-1], sum_im} + {ext_im[ACC_W-1], ext_im};
    assign ovf_re  = full_re[ACC_W] ^ full_re[ACC_W-1];
    assign ovf_im  = full_im[ACC_W] ^ full_im[ACC_W-1];
    assign add_re  = ovf_re ? (full_re[ACC_W] ? MIN_V : MAX_V)
                            : full_re[ACC_W-1:0];
    assign add_im  = ovf_im ? (full_im[ACC_W] ? MIN_V : MAX_V)
                            : full_im[ACC_W-1:0];
    assign add_ovf = ovf_re | ovf_im;
`else
    assign add_re  = sum_re + ext_re;
    assign add_im  = sum_im + ext_im;
    assign add_ovf = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        sum_re_nx = sum_re;
        sum_im_nx = sum_im;
        cnt_nx    = cnt;
        sat_nx    = sat;
        unique case (state)
            IDLE, DUMP: begin
                if (in_valid) begin
                    sum_re_nx = ext_re;
                    sum_im_nx = ext_im;
                    cnt_nx    = CNT_W'(1);
                    sat_nx    = 1'b0;
                    state_nx  = (ACC_LEN == 1 || flush) ? DUMP : ACCUM;
                end else if (state == DUMP) begin
                    sum_re_nx = '0;
                    sum_im_nx = '0;
                    cnt_nx    = '0;
                    sat_nx    = 1'b0;
                    state_nx  = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    sum_re_nx = add_re;
                    sum_im_nx = add_im;
                    cnt_nx    = cnt_inc;
                    sat_nx    = sat | add_ovf;
                    if (cnt_inc == CNT_W'(ACC_LEN) || flush)
                        state_nx = DUMP;
                end else if (flush) begin
                    state_nx = DUMP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sum_re    <= '0;
            sum_im    <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            acc_real  <= '0;
            acc_imag  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            sum_re    <= sum_re_nx;
            sum_im    <= sum_im_nx;
            cnt       <= cnt_nx;
            sat       <= sat_nx;
            out_valid <= (state == DUMP);
            if (state == DUMP) begin
                acc_real  <= sum_re;
                acc_imag  <= sum_im;
                out_count <= cnt;
            end
        end
    end

`ifdef COMPLEX_ACC_SAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_sat <= 1'b0;
        else if (state == DUMP)
            out_sat <= sat;
    end
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_complex_acc.sv
// tb_complex_acc: two complex_acc instances (ACC_LEN 4/ACC_W 17 and ACC_LEN 1/ACC_W 20)
// checked each cycle against a frame-level model, plus directed literal checks.
module tb_complex_acc;

`ifdef COMPLEX_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;

    logic [16:0] a_re, a_im;
    logic [7:0]  a_cnt;
    logic        a_ov, a_busy, a_sat;
    logic [19:0] b_re, b_im;
    logic [7:0]  b_cnt;
    logic        b_ov, b_busy, b_sat;

    always #5 clk = ~clk;

    complex_acc #(.IN_W(16), .ACC_LEN(4), .ACC_W(17), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .flush(flush),
        .acc_real(a_re), .acc_imag(a_im), .out_count(a_cnt),
        .out_valid(a_ov), .busy(a_busy), .out_sat(a_sat)
    );

    complex_acc #(.IN_W(16), .ACC_LEN(1), .ACC_W(20), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .flush(flush),
        .acc_real(b_re), .acc_imag(b_im), .out_count(b_cnt),
        .out_valid(b_ov), .busy(b_busy), .out_sat(b_sat)
    );

    int pass_n = 0;
    int tot_n  = 0;

    task automatic ck(string nm, longint act, longint exp);
        tot_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- frame-level model ----------------
    int     mlen[2] = '{4, 1};
    int     mw[2]   = '{17, 20};
    int     n[2];
    longint er[2], ei[2], cr[2], ci[2];
    bit     fs[2];
    bit     pend[2];
    longint pr[2], pim[2];
    int     pc[2];
    bit     ps[2];
    longint xr[2], xi[2];
    int     xc[2];
    bit     xv[2], xs[2], xb[2];

    function automatic longint wrapv(longint x, int w);
        longint m = longint'(1) << w;
        longint y = x & (m - 1);
        if (y >= m / 2) y -= m;
        return y;
    endfunction

    function automatic longint clampv(longint x, int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_step(int k);
        longint sre, sim, t;
        sre = longint'($signed(in_real));
        sim = longint'($signed(in_imag));
        if (!rst_n) begin
            n[k] = 0; pend[k] = 0;
            xr[k] = 0; xi[k] = 0; xc[k] = 0;
            xv[k] = 0; xs[k] = 0; xb[k] = 0;
            return;
        end
        xv[k] = 0;
        if (pend[k]) begin
            xr[k] = pr[k]; xi[k] = pim[k]; xc[k] = pc[k];
            xs[k] = ps[k]; xv[k] = 1; pend[k] = 0;
        end
        if (in_valid) begin
            if (n[k] == 0) begin
                er[k] = sre; ei[k] = sim;
                cr[k] = sre; ci[k] = sim; fs[k] = 0;
            end else begin
                er[k] += sre; ei[k] += sim;
                t = clampv(cr[k] + sre, mw[k]);
                if (t != cr[k] + sre) fs[k] = 1;
                cr[k] = t;
                t = clampv(ci[k] + sim, mw[k]);
                if (t != ci[k] + sim) fs[k] = 1;
                ci[k] = t;
            end
            n[k]++;
        end
        if (n[k] > 0 && (n[k] == mlen[k] || flush)) begin
            pr[k]  = SAT ? cr[k] : wrapv(er[k], mw[k]);
            pim[k] = SAT ? ci[k] : wrapv(ei[k], mw[k]);
            pc[k]  = n[k];
            ps[k]  = SAT ? fs[k] : 1'b0;
            pend[k] = 1;
            n[k] = 0;
        end
        xb[k] = (n[k] > 0) || pend[k];
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        ck("a_valid", a_ov, xv[0]);
        ck("a_busy", a_busy, xb[0]);
        ck("a_re", $signed(a_re), xr[0]);
        ck("a_im", $signed(a_im), xi[0]);
        ck("a_cnt", a_cnt, xc[0]);
        ck("a_sat", a_sat, xs[0]);
        ck("b_valid", b_ov, xv[1]);
        ck("b_busy", b_busy, xb[1]);
        ck("b_re", $signed(b_re), xr[1]);
        ck("b_im", $signed(b_im), xi[1]);
        ck("b_cnt", b_cnt, xc[1]);
        ck("b_sat", b_sat, xs[1]);
    end

    task automatic step(bit v, longint r, longint i, bit f);
        in_valid = v;
        in_real  = 16'(r);
        in_imag  = 16'(i);
        flush    = f;
        @(negedge clk);
    endtask

    task automatic ck_a(string nm, longint r, longint i, int c);
        ck({nm, "_valid"}, a_ov, 1);
        ck({nm, "_re"}, $signed(a_re), r);
        ck({nm, "_im"}, $signed(a_im), i);
        ck({nm, "_cnt"}, a_cnt, c);
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        ck("rst_a_re", a_re, 0);
        ck("rst_a_valid", a_ov, 0);
        ck("rst_a_busy", a_busy, 0);
        rst_n = 1'b1;

        // sequential frame of four
        for (int s = 1; s <= 4; s++) step(1, s, -s, 0);
        step(0, 0, 0, 0);
        ck_a("t1", 10, -10, 4);
        ck("t1_model_re", xr[0], 10);
        step(0, 0, 0, 0);
        ck("t1_pulse_low", a_ov, 0);
        ck("t1_busy_low", a_busy, 0);

        // back-to-back frames, next frame starts in dump cycle
        for (int s = 0; s < 4; s++) step(1, 5, 0, 0);
        step(1, 7, 0, 0);
        ck_a("t2a", 20, 0, 4);
        for (int s = 0; s < 3; s++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        ck_a("t2b", 10, 0, 4);

        // early flush, then flush in idle
        step(1, 100, 50, 0);
        step(1, -30, 20, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        ck_a("t3", 70, 70, 2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        ck("t3_idle_flush", a_ov, 0);
        ck("t3_idle_busy", a_busy, 0);

        // reset discards partial frame
        for (int s = 0; s < 3; s++) step(1, 9, 9, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        ck("t4_re", a_re, 0);
        ck("t4_cnt", a_cnt, 0);
        ck("t4_busy", a_busy, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) step(1, 1, 2, 0);
        step(0, 0, 0, 0);
        ck_a("t4", 4, 8, 4);

        // overflow at ACC_W=17
        for (int s = 0; s < 4; s++) step(1, 32767, -32768, 0);
        step(0, 0, 0, 0);
        if (SAT) ck_a("t5s", 65535, -65536, 4);
        else ck_a("t5w", -4, 0, 4);
        ck("t5_sat", a_sat, SAT ? 1 : 0);

        // single-sample frames with gaps
        step(1, -5, 6, 0);
        step(0, 0, 0, 0);
        ck("t6_valid", b_ov, 1);
        ck("t6_re", $signed(b_re), -5);
        ck("t6_im", $signed(b_im), 6);
        ck("t6_cnt", b_cnt, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 7, -8, 0);
        step(0, 0, 0, 0);
        ck("t6b_valid", b_ov, 1);
        ck("t6b_re", $signed(b_re), 7);
        ck("t6b_im", $signed(b_im), -8);
        ck("t6b_cnt", b_cnt, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            longint r, i;
            rst_n = ($urandom_range(0, 199) != 0);
            case ($urandom_range(0, 3))
                0: begin
                    r = $urandom_range(0, 1) ? 32767 : -32768;
                    i = $urandom_range(0, 1) ? 32767 : -32768;
                end
                1: begin
                    r = longint'($urandom_range(0, 200)) - 100;
                    i = longint'($urandom_range(0, 200)) - 100;
                end
                default: begin
                    r = longint'($urandom_range(0, 65535)) - 32768;
                    i = longint'($urandom_range(0, 65535)) - 32768;
                end
            endcase
            step($urandom_range(0, 9) < 7, r, i, $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
